// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the instruction/data cache to memory arbiter:
// FSM states, Grant codes, request types, owner ids and bus widths.
package mem_arbiter_pkg;

    localparam int WORD_W             = 32;
    localparam int ADDR_W             = 32;
    localparam int DEFAULT_BLOCK_SIZE = 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_RELEASE = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'b00,
        GRANT_I    = 2'b01,
        GRANT_D    = 2'b10
    } grant_t;

    // Bit 0 = read strobe, bit 1 = write-through strobe; both = sw-miss.
    typedef enum logic [1:0] {
        REQ_NONE   = 2'b00,
        REQ_READ   = 2'b01,
        REQ_WRITE  = 2'b10,
        REQ_SWMISS = 2'b11
    } req_type_t;

    localparam logic OWNER_I = 1'b0;
    localparam logic OWNER_D = 1'b1;

    function automatic logic type_reads(input req_type_t t);
        return t[0];
    endfunction

    function automatic logic type_writes(input req_type_t t);
        return t[1];
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin selector: bit 0 = I-cache, bit 1 = D-cache.
// On contention the requester that was not served last wins.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_served == OWNER_I) ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the I-cache and D-cache miss/write-through traffic onto one
// data-memory port, one transaction at a time, with round-robin fairness.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int BLOCK_SIZE = DEFAULT_BLOCK_SIZE
)
(
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [ADDR_W-1:0]            I_Address,
    input  logic                         I_ReadMiss,
    output logic [WORD_W*BLOCK_SIZE-1:0] I_Read_data,
    output logic                         I_ReadReady,
    input  logic [ADDR_W-1:0]            D_Address,
    input  logic                         D_ReadMiss,
    input  logic                         D_MemWriteThrough,
    input  logic [WORD_W-1:0]            D_Write_data,
    output logic [WORD_W*BLOCK_SIZE-1:0] D_Read_data,
    output logic                         D_ReadReady,
    output logic                         D_WriteReady,
    output logic [ADDR_W-1:0]            Mem_Address,
    output logic [WORD_W-1:0]            Mem_Write_data,
    output logic                         Mem_ReadMiss,
    output logic                         Mem_MemWriteThrough,
    input  logic [WORD_W*BLOCK_SIZE-1:0] Mem_Read_data,
    input  logic                         Mem_ReadReady,
    input  logic                         Mem_WriteReady,
    output logic [1:0]                   Grant
);

    localparam int BLK_W = WORD_W * BLOCK_SIZE;

    arb_state_t         state, state_next;
    logic               owner, last_served;
    req_type_t          type_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [WORD_W-1:0]  wdata_q;
    logic [BLK_W-1:0]   i_block_q, d_block_q;
    logic [1:0]         req, gnt;
    logic               done, fwd_i, fwd_dr, fwd_dw;

    assign req = {D_ReadMiss | D_MemWriteThrough, I_ReadMiss};

    rr_arb2 u_rr_arb2 (
        .req         (req),
        .last_served (last_served),
        .gnt         (gnt)
    );

    // Only the ready matching the latched request type can end the wait.
    assign done = (state == ST_WAIT) &&
                  (type_reads(type_q) ? Mem_ReadReady : Mem_WriteReady);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (|gnt) state_next = ST_ISSUE;
            ST_ISSUE:   state_next = ST_WAIT;
            ST_WAIT:    if (done) state_next = ST_RELEASE;
            ST_RELEASE: state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    // Transaction registers: requests are sampled only in IDLE, so later
    // changes on the cache side cannot disturb an in-flight transaction.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            owner       <= OWNER_I;
            last_served <= OWNER_I;
            type_q      <= REQ_NONE;
            addr_q      <= '0;
            wdata_q     <= '0;
            i_block_q   <= '0;
            d_block_q   <= '0;
        end else begin
            if (state == ST_IDLE && gnt[1]) begin
                owner   <= OWNER_D;
                addr_q  <= D_Address;
                wdata_q <= D_Write_data;
                type_q  <= req_type_t'({D_MemWriteThrough, D_ReadMiss});
            end else if (state == ST_IDLE && gnt[0]) begin
                owner   <= OWNER_I;
                addr_q  <= I_Address;
                wdata_q <= '0;
                type_q  <= REQ_READ;
            end
            if (done) begin
                last_served <= owner;
            end
            if (fwd_i) begin
                i_block_q <= Mem_Read_data;
            end
            if (fwd_dr) begin
                d_block_q <= Mem_Read_data;
            end
        end
    end

    always_comb begin
        fwd_i  = done && (owner == OWNER_I);
        fwd_dr = done && (owner == OWNER_D) && type_reads(type_q);
        fwd_dw = done && (owner == OWNER_D) && (type_q == REQ_WRITE);

        I_ReadReady  = fwd_i;
        D_ReadReady  = fwd_dr;
        D_WriteReady = fwd_dw;
        I_Read_data  = fwd_i  ? Mem_Read_data : i_block_q;
        D_Read_data  = fwd_dr ? Mem_Read_data : d_block_q;

        Mem_Address         = addr_q;
        Mem_Write_data      = wdata_q;
        Mem_ReadMiss        = (state == ST_ISSUE) && type_reads(type_q);
        Mem_MemWriteThrough = (state == ST_ISSUE) && type_writes(type_q);

        Grant = GRANT_NONE;
        if (state == ST_ISSUE || state == ST_WAIT) begin
            Grant = (owner == OWNER_D) ? GRANT_D : GRANT_I;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a fixed-latency behavioural data memory.
module tb_mem_arbiter;

    localparam int LAT = 20;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] I_Address, D_Address, D_Write_data;
    logic        I_ReadMiss, D_ReadMiss, D_MemWriteThrough;
    logic [31:0] I_Read_data, D_Read_data;
    logic        I_ReadReady, D_ReadReady, D_WriteReady;
    logic [31:0] Mem_Address, Mem_Write_data, Mem_Read_data;
    logic        Mem_ReadMiss, Mem_MemWriteThrough, Mem_ReadReady, Mem_WriteReady;
    logic [1:0]  Grant;

    always #5 Clk = ~Clk;

    mem_arbiter #(.BLOCK_SIZE(1)) dut (
        .Clk(Clk), .Rst(Rst),
        .I_Address(I_Address), .I_ReadMiss(I_ReadMiss),
        .I_Read_data(I_Read_data), .I_ReadReady(I_ReadReady),
        .D_Address(D_Address), .D_ReadMiss(D_ReadMiss),
        .D_MemWriteThrough(D_MemWriteThrough), .D_Write_data(D_Write_data),
        .D_Read_data(D_Read_data), .D_ReadReady(D_ReadReady), .D_WriteReady(D_WriteReady),
        .Mem_Address(Mem_Address), .Mem_Write_data(Mem_Write_data),
        .Mem_ReadMiss(Mem_ReadMiss), .Mem_MemWriteThrough(Mem_MemWriteThrough),
        .Mem_Read_data(Mem_Read_data), .Mem_ReadReady(Mem_ReadReady),
        .Mem_WriteReady(Mem_WriteReady), .Grant(Grant)
    );

    // Memory model: strobe sampled at edge n, ready high in the cycle after edge n+LAT.
    logic [31:0] mem [0:63];
    logic        mem_vld [0:63] = '{default: 1'b0};
    logic        mdl_busy = 1'b0, mdl_rd = 1'b0, mdl_rrdy = 1'b0, mdl_wrdy = 1'b0;
    logic        inj_rrdy = 1'b0, inj_wrdy = 1'b0;
    int          mdl_cnt = 0;
    logic [31:0] mdl_addr = '0, mdl_rdata = '0;

    assign Mem_ReadReady  = mdl_rrdy | inj_rrdy;
    assign Mem_WriteReady = mdl_wrdy | inj_wrdy;
    assign Mem_Read_data  = mdl_rdata;

    function automatic logic [31:0] pattern(input logic [31:0] a);
        return 32'hA500_0000 | a;
    endfunction

    always @(posedge Clk) begin
        mdl_rrdy <= 1'b0;
        mdl_wrdy <= 1'b0;
        if (Mem_ReadMiss || Mem_MemWriteThrough) begin
            mdl_busy <= 1'b1;
            mdl_cnt  <= LAT;
            mdl_addr <= Mem_Address;
            mdl_rd   <= Mem_ReadMiss;
            if (Mem_MemWriteThrough) begin
                mem[Mem_Address[7:2]]     <= Mem_Write_data;
                mem_vld[Mem_Address[7:2]] <= 1'b1;
            end
        end else if (mdl_busy) begin
            mdl_cnt <= mdl_cnt - 1;
            if (mdl_cnt == 1) begin
                mdl_busy <= 1'b0;
                if (mdl_rd) begin
                    mdl_rrdy  <= 1'b1;
                    mdl_rdata <= mem_vld[mdl_addr[7:2]] ? mem[mdl_addr[7:2]] : pattern(mdl_addr);
                end else begin
                    mdl_wrdy <= 1'b1;
                end
            end
        end
    end

    // Event counters observed away from the active edge.
    int cyc = 0;
    int n_ms = 0, n_mw = 0, n_both = 0, n_irdy = 0, n_drdy = 0, n_dwrdy = 0;
    logic [31:0] last_ms_addr = '0, last_mw_addr = '0, last_mw_data = '0;

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (Mem_ReadMiss) begin
            n_ms <= n_ms + 1;
            last_ms_addr <= Mem_Address;
        end
        if (Mem_MemWriteThrough) begin
            n_mw <= n_mw + 1;
            last_mw_addr <= Mem_Address;
            last_mw_data <= Mem_Write_data;
        end
        if (Mem_ReadMiss && Mem_MemWriteThrough) n_both <= n_both + 1;
        if (I_ReadReady)  n_irdy  <= n_irdy + 1;
        if (D_ReadReady)  n_drdy  <= n_drdy + 1;
        if (D_WriteReady) n_dwrdy <= n_dwrdy + 1;
    end

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1 Rst = 1'b0;
    endtask

    // which: 0 = I read, 1 = D read/sw-miss, 2 = D write. hold: extra cycles request stays up.
    task automatic wait_ready(input int which, input int hold, input int t0,
                              output int lat, output logic [31:0] data);
        lat  = -1;
        data = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge Clk);
            if ((which == 0 && I_ReadReady) || (which == 1 && D_ReadReady) ||
                (which == 2 && D_WriteReady)) begin
                lat  = cyc - t0;
                data = (which == 0) ? I_Read_data : D_Read_data;
                break;
            end
        end
        if (hold > 0) begin
            repeat (hold + 1) @(posedge Clk);
            #1;
        end
        if (which == 0) begin
            I_ReadMiss = 1'b0;
        end else begin
            D_ReadMiss        = 1'b0;
            D_MemWriteThrough = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, lat, tD, tI, tD2, gI;
        int s_ms, s_mw, s_both, s_irdy, s_drdy, s_dwrdy;
        logic [31:0] data, dD, dI, dD2;

        I_Address = '0; D_Address = '0; D_Write_data = '0;
        I_ReadMiss = 1'b0; D_ReadMiss = 1'b0; D_MemWriteThrough = 1'b0;
        do_reset();

        @(negedge Clk);
        chk("rst_grant", 32'(Grant), 32'h0);
        chk("rst_readies", 32'({I_ReadReady, D_ReadReady, D_WriteReady}), 32'h0);
        chk("rst_strobes", 32'({Mem_ReadMiss, Mem_MemWriteThrough}), 32'h0);
        chk("rst_mem_addr", Mem_Address, 32'h0);
        chk("rst_i_data", I_Read_data, 32'h0);
        chk("rst_d_data", D_Read_data, 32'h0);

        // Stray memory readies while idle must not reach the caches.
        @(posedge Clk); #1 inj_rrdy = 1'b1; inj_wrdy = 1'b1;
        @(negedge Clk);
        chk("stray_idle_readies", 32'({I_ReadReady, D_ReadReady, D_WriteReady}), 32'h0);
        @(posedge Clk); #1 inj_rrdy = 1'b0; inj_wrdy = 1'b0;

        // Single I-cache read of 0x40.
        s_ms = n_ms; s_drdy = n_drdy; s_dwrdy = n_dwrdy;
        @(posedge Clk); #1;
        I_Address = 32'h40; I_ReadMiss = 1'b1; t0 = cyc;
        repeat (3) @(negedge Clk);
        chk("i_rd_grant_wait", 32'(Grant), 32'h1);
        wait_ready(0, 0, t0, lat, data);
        chk("i_rd_latency", lat, 22);
        chk("i_rd_data", data, 32'hA500_0040);
        repeat (4) @(negedge Clk);
        chk("i_rd_strobes", n_ms - s_ms, 1);
        chk("i_rd_mem_addr", last_ms_addr, 32'h40);
        chk("i_rd_no_d_ready", (n_drdy - s_drdy) + (n_dwrdy - s_dwrdy), 0);
        chk("i_rd_data_hold", I_Read_data, 32'hA500_0040);
        chk("i_rd_grant_idle", 32'(Grant), 32'h0);

        // D write-through 0x10 with a stray read-ready injected during WAIT.
        s_ms = n_ms; s_mw = n_mw; s_irdy = n_irdy; s_drdy = n_drdy; s_dwrdy = n_dwrdy;
        @(posedge Clk); #1;
        D_Address = 32'h10; D_Write_data = 32'hDEAD_BEEF; D_MemWriteThrough = 1'b1; t0 = cyc;
        repeat (3) @(negedge Clk);
        chk("d_wr_grant_wait", 32'(Grant), 32'h2);
        @(posedge Clk); #1 inj_rrdy = 1'b1;
        @(posedge Clk); #1 inj_rrdy = 1'b0;
        wait_ready(2, 0, t0, lat, data);
        chk("d_wr_latency", lat, 22);
        repeat (4) @(negedge Clk);
        chk("d_wr_wt_strobes", n_mw - s_mw, 1);
        chk("d_wr_no_rd_strobe", n_ms - s_ms, 0);
        chk("d_wr_mem_addr", last_mw_addr, 32'h10);
        chk("d_wr_mem_data", last_mw_data, 32'hDEAD_BEEF);
        chk("d_wr_wready_cnt", n_dwrdy - s_dwrdy, 1);
        chk("d_wr_no_rready", n_drdy - s_drdy, 0);
        chk("d_wr_no_i_ready", n_irdy - s_irdy, 0);

        // Read the written word back through the D side.
        @(posedge Clk); #1;
        D_Address = 32'h10; D_ReadMiss = 1'b1; t0 = cyc;
        wait_ready(1, 0, t0, lat, data);
        chk("d_rd_back_latency", lat, 22);
        chk("d_rd_back_data", data, 32'hDEAD_BEEF);

        // D sw-miss at 0x20: both strobes together, completes on read ready.
        repeat (3) @(posedge Clk);
        s_ms = n_ms; s_mw = n_mw; s_both = n_both; s_drdy = n_drdy; s_dwrdy = n_dwrdy;
        #1;
        D_Address = 32'h20; D_Write_data = 32'h1234_5678;
        D_ReadMiss = 1'b1; D_MemWriteThrough = 1'b1; t0 = cyc;
        wait_ready(1, 0, t0, lat, data);
        chk("swm_latency", lat, 22);
        chk("swm_data", data, 32'h1234_5678);
        repeat (4) @(negedge Clk);
        chk("swm_both_strobes", n_both - s_both, 1);
        chk("swm_rd_strobes", n_ms - s_ms, 1);
        chk("swm_wt_strobes", n_mw - s_mw, 1);
        chk("swm_rready_cnt", n_drdy - s_drdy, 1);
        chk("swm_no_wready", n_dwrdy - s_dwrdy, 0);
        chk("swm_data_hold", D_Read_data, 32'h1234_5678);

        // Contention after reset: D first, then I, then a re-request from D.
        do_reset();
        @(posedge Clk); #1;
        I_Address = 32'h44; I_ReadMiss = 1'b1;
        D_Address = 32'h48; D_ReadMiss = 1'b1; t0 = cyc;
        tD = -1; tI = -1; tD2 = -1; gI = -1;
        dD = '0; dI = '0; dD2 = '0;
        for (int k = 0; k < 120; k++) begin
            @(negedge Clk);
            if (D_ReadReady && tD >= 0) begin
                tD2 = cyc; dD2 = D_Read_data; D_ReadMiss = 1'b0;
                break;
            end
            if (D_ReadReady) begin
                tD = cyc; dD = D_Read_data; D_ReadMiss = 1'b0;
            end
            if (I_ReadReady) begin
                tI = cyc; dI = I_Read_data; I_ReadMiss = 1'b0;
            end
            if (Grant == 2'b01 && gI < 0) gI = cyc;
            if (tD >= 0 && cyc == tD + 1) begin
                D_Address = 32'h4C; D_ReadMiss = 1'b1;
            end
        end
        chk("cont_d_first_lat", tD - t0, 22);
        chk("cont_d_data", dD, 32'hA500_0048);
        chk("cont_i_grant_gap", gI - tD, 3);
        chk("cont_i_ready", tI - tD, 24);
        chk("cont_i_data", dI, 32'hA500_0044);
        chk("cont_d_again", tD2 - tI, 24);
        chk("cont_d_again_data", dD2, 32'hA500_004C);

        // Reset while waiting on memory aborts the read; the late ready is dropped.
        repeat (3) @(posedge Clk);
        s_ms = n_ms; s_irdy = n_irdy; s_drdy = n_drdy; s_dwrdy = n_dwrdy;
        #1;
        I_Address = 32'h40; I_ReadMiss = 1'b1;
        repeat (5) @(posedge Clk);
        #1 Rst = 1'b1; I_ReadMiss = 1'b0;
        @(posedge Clk); #1 Rst = 1'b0;
        @(negedge Clk);
        chk("rstw_grant", 32'(Grant), 32'h0);
        chk("rstw_strobes", 32'({Mem_ReadMiss, Mem_MemWriteThrough}), 32'h0);
        repeat (30) @(negedge Clk);
        chk("rstw_no_i_ready", n_irdy - s_irdy, 0);
        chk("rstw_no_d_ready", (n_drdy - s_drdy) + (n_dwrdy - s_dwrdy), 0);
        chk("rstw_one_strobe", n_ms - s_ms, 1);
        chk("rstw_i_data_clr", I_Read_data, 32'h0);

        // Request held one cycle past ready must not start a second transaction.
        s_ms = n_ms; s_drdy = n_drdy;
        @(posedge Clk); #1;
        D_Address = 32'h30; D_ReadMiss = 1'b1; t0 = cyc;
        wait_ready(1, 1, t0, lat, data);
        chk("hold_latency", lat, 22);
        chk("hold_data", data, 32'hA500_0030);
        repeat (10) @(negedge Clk);
        chk("hold_one_strobe", n_ms - s_ms, 1);
        chk("hold_one_ready", n_drdy - s_drdy, 1);
        chk("hold_grant_idle", 32'(Grant), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
